// File: rtl/sram_axi_arbiter_pkg.sv
// Shared definitions for the SRAM-to-AXI arbiter: FSM encoding, default AXI IDs
// and the fixed single-beat burst attributes.
package sram_axi_arbiter_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_RESP = 3'd4
    } state_e;

    localparam logic [3:0] INST_ID_DEF    = 4'd0;
    localparam logic [3:0] DATA_ID_DEF    = 4'd1;

    localparam logic [7:0] AXI_LEN        = 8'd0;
    localparam logic [2:0] AXI_SIZE       = 3'd2;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/sram_axi_arbiter.sv
// Arbitrates the fetch and data SRAM-style ports onto one single-outstanding AXI
// master, issuing each access as a single-beat read or write transaction.
module sram_axi_arbiter
    import sram_axi_arbiter_pkg::*;
#(
    parameter int         ADDR_WD = 32,
    parameter int         DATA_WD = 32,
    parameter logic [3:0] INST_ID = INST_ID_DEF,
    parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
    input  logic               clk,
    input  logic               reset,
    // fetch port
    input  logic               inst_req,
    input  logic [ADDR_WD-1:0] inst_addr,
    input  logic               inst_cancel,
    output logic               inst_done,
    output logic [DATA_WD-1:0] inst_rdata,
    // data port
    input  logic               data_req,
    input  logic               data_wr,
    input  logic [3:0]         data_wstrb,
    input  logic [ADDR_WD-1:0] data_addr,
    input  logic [DATA_WD-1:0] data_wdata,
    output logic               data_done,
    output logic [DATA_WD-1:0] data_rdata,
    output logic               stallreq_axi,
    // AXI read address
    output logic               arvalid,
    input  logic               arready,
    output logic [ADDR_WD-1:0] araddr,
    output logic [3:0]         arid,
    output logic [7:0]         arlen,
    output logic [2:0]         arsize,
    output logic [1:0]         arburst,
    // AXI read data
    input  logic               rvalid,
    output logic               rready,
    input  logic [DATA_WD-1:0] rdata,
    input  logic [3:0]         rid,
    input  logic               rlast,
    // AXI write address
    output logic               awvalid,
    input  logic               awready,
    output logic [ADDR_WD-1:0] awaddr,
    output logic [3:0]         awid,
    output logic [7:0]         awlen,
    output logic [2:0]         awsize,
    output logic [1:0]         awburst,
    // AXI write data
    output logic               wvalid,
    input  logic               wready,
    output logic [DATA_WD-1:0] wdata,
    output logic [3:0]         wstrb,
    output logic               wlast,
    // AXI write response
    input  logic               bvalid,
    output logic               bready
);

    state_e             state_q;
    logic               owner_q;     // 1 = data port owns the bus
    logic [ADDR_WD-1:0] addr_q;
    logic [3:0]         wstrb_q;
    logic [DATA_WD-1:0] wdata_q;
    logic               aw_ok_q, w_ok_q, cancel_q;
    logic               arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic               inst_done_q, data_done_q;
    logic [DATA_WD-1:0] inst_rdata_q, data_rdata_q;

    // A requester whose done pulses this cycle has already been served.
    logic inst_ok, data_ok, aw_acc, w_acc, cancel_now;
    assign inst_ok    = inst_req & ~inst_done_q;
    assign data_ok    = data_req & ~data_done_q;
    assign aw_acc     = aw_ok_q | (awvalid_q & awready);
    assign w_acc      = w_ok_q  | (wvalid_q  & wready);
    assign cancel_now = cancel_q | inst_cancel;

    // Only one transaction is outstanding, so response IDs carry no information.
    logic unused_rsp;
    assign unused_rsp = ^{rid, rlast};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            wstrb_q      <= '0;
            wdata_q      <= '0;
            aw_ok_q      <= 1'b0;
            w_ok_q       <= 1'b0;
            cancel_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            inst_done_q <= 1'b0;
            data_done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    cancel_q <= 1'b0;
                    if (data_ok) begin
                        owner_q <= 1'b1;
                        addr_q  <= data_addr;
                        wstrb_q <= data_wstrb;
                        wdata_q <= data_wdata;
                        // direction is carried by the state itself
                        if (data_wr) begin
                            state_q   <= S_WR_REQ;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state_q   <= S_RD_ADDR;
                            arvalid_q <= 1'b1;
                        end
                    end else if (inst_ok) begin
                        owner_q   <= 1'b0;
                        addr_q    <= inst_addr;
                        wstrb_q   <= '0;
                        wdata_q   <= '0;
                        cancel_q  <= inst_cancel;
                        state_q   <= S_RD_ADDR;
                        arvalid_q <= 1'b1;
                    end
                end
                S_RD_ADDR: begin
                    if (!owner_q && inst_cancel) cancel_q <= 1'b1;
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (rvalid) begin
                        rready_q <= 1'b0;
                        cancel_q <= 1'b0;
                        state_q  <= S_IDLE;
                        if (owner_q) begin
                            data_rdata_q <= rdata;
                            data_done_q  <= 1'b1;
                        end else if (!cancel_now) begin
                            inst_rdata_q <= rdata;
                            inst_done_q  <= 1'b1;
                        end
                    end else if (!owner_q && inst_cancel) begin
                        cancel_q <= 1'b1;
                    end
                end
                S_WR_REQ: begin
                    if (awvalid_q && awready) begin
                        awvalid_q <= 1'b0;
                        aw_ok_q   <= 1'b1;
                    end
                    if (wvalid_q && wready) begin
                        wvalid_q <= 1'b0;
                        w_ok_q   <= 1'b1;
                    end
                    if (aw_acc && w_acc) begin
                        aw_ok_q  <= 1'b0;
                        w_ok_q   <= 1'b0;
                        bready_q <= 1'b1;
                        state_q  <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (bvalid) begin
                        bready_q    <= 1'b0;
                        data_done_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign inst_done    = inst_done_q;
    assign inst_rdata   = inst_rdata_q;
    assign data_done    = data_done_q;
    assign data_rdata   = data_rdata_q;
    assign stallreq_axi = (inst_req & ~inst_done_q) | (data_req & ~data_done_q);

    assign arvalid = arvalid_q;
    assign araddr  = addr_q;
    assign arid    = owner_q ? DATA_ID : INST_ID;
    assign arlen   = AXI_LEN;
    assign arsize  = AXI_SIZE;
    assign arburst = AXI_BURST_INCR;
    assign rready  = rready_q;

    assign awvalid = awvalid_q;
    assign awaddr  = addr_q;
    assign awid    = DATA_ID;
    assign awlen   = AXI_LEN;
    assign awsize  = AXI_SIZE;
    assign awburst = AXI_BURST_INCR;
    assign wvalid  = wvalid_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;
    assign bready  = bready_q;

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Directed and randomized checks of sram_axi_arbiter against a delay-programmable
// AXI slave and a latency/ordering model computed from the channel delays.
module tb_sram_axi_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_cancel, inst_done;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_done;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        stallreq_axi;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [31:0] araddr, rdata;
    logic [3:0]  arid, rid;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [31:0] awaddr, wdata;
    logic [3:0]  awid, wstrb;

    sram_axi_arbiter dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
        .inst_done(inst_done), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_done(data_done), .data_rdata(data_rdata), .stallreq_axi(stallreq_axi),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rlast(rlast),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int ncomp = 0;
    int nfail = 0;

    // Slave: each channel's ready/valid appears after a programmable number of cycles.
    int          ar_d, r_d, aw_d, w_d, b_d;
    int          ar_c, r_c, aw_c, w_c, b_c;
    bit          r_pend, b_pend, aw_seen, w_seen, force_en;
    logic [31:0] r_word, force_word;
    logic [31:0] last_araddr, last_awaddr, last_wdata;
    logic [3:0]  last_arid, last_awid, last_wstrb;
    int          n_ar_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic slave_drive();
        arready = arvalid && (ar_c >= ar_d);
        rvalid  = r_pend && (r_c >= r_d);
        rdata   = rvalid ? r_word : 32'h0;
        rid     = last_arid;
        rlast   = 1'b1;
        awready = awvalid && (aw_c >= aw_d);
        wready  = wvalid && (w_c >= w_d);
        bvalid  = b_pend && (b_c >= b_d);
    endtask

    task automatic slave_reset();
        ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
        r_pend = 0; b_pend = 0; aw_seen = 0; w_seen = 0;
        r_word = 32'h0;
        last_arid = 4'h0;
        slave_drive();
    endtask

    task automatic set_delays(input int a, input int r, input int aw, input int w, input int b);
        ar_d = a; r_d = r; aw_d = aw; w_d = w; b_d = b;
    endtask

    // Advance one clock; inputs are updated 1ns after the rising edge.
    task automatic tick();
        bit ar_hs, r_hs, aw_hs, w_hs, b_hs, arv, awv, wv, rp, bp;
        logic [31:0] p_araddr, p_awaddr, p_wdata;
        logic [3:0]  p_arid, p_awid, p_wstrb;
        ar_hs = arvalid && arready; r_hs = rvalid && rready;
        aw_hs = awvalid && awready; w_hs = wvalid && wready; b_hs = bvalid && bready;
        arv = arvalid; awv = awvalid; wv = wvalid; rp = r_pend; bp = b_pend;
        p_araddr = araddr; p_arid = arid; p_awaddr = awaddr; p_awid = awid;
        p_wdata = wdata; p_wstrb = wstrb;
        @(posedge clk);
        #1;
        if (r_hs) r_pend = 0;
        else if (rp) r_c++;
        if (ar_hs) begin
            ar_c = 0; r_pend = 1; r_c = 0;
            last_araddr = p_araddr; last_arid = p_arid;
            if (p_arid == 4'd1) n_ar_data++;
            r_word = force_en ? force_word : $urandom;
            force_en = 0;
        end else if (arv) ar_c++;
        if (aw_hs) begin
            aw_c = 0; aw_seen = 1; last_awaddr = p_awaddr; last_awid = p_awid;
        end else if (awv) aw_c++;
        if (w_hs) begin
            w_c = 0; w_seen = 1; last_wdata = p_wdata; last_wstrb = p_wstrb;
        end else if (wv) w_c++;
        if (b_hs) b_pend = 0;
        else if (bp) b_c++;
        if (aw_seen && w_seen) begin
            aw_seen = 0; w_seen = 0; b_pend = 1; b_c = 0;
        end
        slave_drive();
    endtask

    task automatic wait_done(input bit is_inst, input int bound, output int lat);
        bit ok;
        ok = 0; lat = 0;
        while (!ok && lat < bound) begin
            tick();
            lat++;
            if (is_inst ? inst_done : data_done) ok = 1;
        end
        chk(is_inst ? "inst_done_timeout" : "data_done_timeout", ok, 1'b1);
    endtask

    initial begin
        int lat, kind, exp_lat, a, r, aw, w, b;
        bit saw;
        logic [31:0] addr, wd;
        logic [3:0]  ws;

        inst_req = 0; inst_addr = 0; inst_cancel = 0;
        data_req = 0; data_wr = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
        force_en = 0; force_word = 0; n_ar_data = 0;
        last_araddr = 0; last_awaddr = 0; last_wdata = 0; last_awid = 0; last_wstrb = 0;
        set_delays(0, 0, 0, 0, 0);
        reset = 1;
        slave_reset();
        @(posedge clk); #1;
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_bready", bready, 1'b0);
        chk("rst_done", {inst_done, data_done}, 2'b00);
        chk("rst_rdata", {inst_rdata, data_rdata}, 64'h0);
        chk("rst_stall", stallreq_axi, 1'b0);
        chk("const_ar", {arlen, arsize, arburst}, {8'd0, 3'd2, 2'd1});
        chk("const_aw", {awlen, awsize, awburst, wlast}, {8'd0, 3'd2, 2'd1, 1'b1});
        reset = 0;
        tick();

        // Instruction read, zero-wait slave
        inst_req = 1; inst_addr = 32'h1C00_0000;
        force_word = 32'h0280_0C0C; force_en = 1;
        #1 chk("t1_stall_grant", stallreq_axi, 1'b1);
        tick();
        chk("t1_arvalid", arvalid, 1'b1);
        chk("t1_araddr", araddr, 32'h1C00_0000);
        chk("t1_arid", arid, 4'd0);
        chk("t1_stall", stallreq_axi, 1'b1);
        tick();
        chk("t1_rready", rready, 1'b1);
        chk("t1_done_early", inst_done, 1'b0);
        tick();
        chk("t1_done", inst_done, 1'b1);
        chk("t1_rdata", inst_rdata, 32'h0280_0C0C);
        chk("t1_stall_done", stallreq_axi, 1'b0);
        inst_req = 0;
        tick();
        chk("t1_done_pulse", inst_done, 1'b0);

        // Simultaneous requests: data goes first
        inst_req = 1; inst_addr = 32'h1C00_0004;
        data_req = 1; data_wr = 0; data_addr = 32'h0000_1000;
        force_word = 32'hA5A5_0001; force_en = 1;
        tick();
        chk("t2_arid_data", arid, 4'd1);
        chk("t2_araddr_data", araddr, 32'h0000_1000);
        tick();
        tick();
        chk("t2_data_done", data_done, 1'b1);
        chk("t2_data_rdata", data_rdata, 32'hA5A5_0001);
        chk("t2_inst_not_done", inst_done, 1'b0);
        data_req = 0;
        force_word = 32'h0BAD_F00D; force_en = 1;
        tick();
        chk("t2_arvalid_inst", arvalid, 1'b1);
        chk("t2_arid_inst", arid, 4'd0);
        chk("t2_araddr_inst", araddr, 32'h1C00_0004);
        chk("t2_data_pulse", data_done, 1'b0);
        wait_done(1'b1, 20, lat);
        chk("t2_inst_lat", lat, 2);
        chk("t2_inst_rdata", inst_rdata, 32'h0BAD_F00D);
        chk("t2_one_data_ar", n_ar_data, 1);
        inst_req = 0;
        tick();

        // Write with awready delayed by two cycles
        set_delays(0, 0, 2, 0, 0);
        data_req = 1; data_wr = 1; data_wstrb = 4'b0011;
        data_wdata = 32'hDEAD_BEEF; data_addr = 32'h0000_2000;
        tick();
        chk("t3_aw_w_c1", {awvalid, wvalid}, 2'b11);
        tick();
        chk("t3_aw_w_c2", {awvalid, wvalid}, 2'b10);
        tick();
        chk("t3_aw_w_c3", {awvalid, wvalid}, 2'b10);
        tick();
        chk("t3_resp", {awvalid, bready, data_done}, 3'b010);
        tick();
        chk("t3_done", data_done, 1'b1);
        chk("t3_awaddr", last_awaddr, 32'h0000_2000);
        chk("t3_awid", last_awid, 4'd1);
        chk("t3_wdata", last_wdata, 32'hDEAD_BEEF);
        chk("t3_wstrb", last_wstrb, 4'b0011);
        data_req = 0; data_wr = 0;
        tick();
        chk("t3_done_pulse", data_done, 1'b0);
        set_delays(0, 0, 0, 0, 0);

        // Cancel during RD_DATA: result is discarded
        set_delays(0, 2, 0, 0, 0);
        inst_req = 1; inst_addr = 32'h1C00_0100;
        force_word = 32'h1234_5678; force_en = 1;
        tick();
        tick();
        chk("t4_rready", rready, 1'b1);
        inst_cancel = 1; inst_req = 0;
        saw = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            inst_cancel = 0;
            if (inst_done) saw = 1;
        end
        chk("t4_no_done", saw, 1'b0);
        chk("t4_rdata_kept", inst_rdata, 32'h0BAD_F00D);
        chk("t4_idle", {arvalid, rready}, 2'b00);
        set_delays(0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a read
        set_delays(0, 3, 0, 0, 0);
        inst_req = 1; inst_addr = 32'h1C00_0200;
        tick();
        tick();
        chk("t5_rready_pre", rready, 1'b1);
        #2 reset = 1;
        #1;
        chk("t5_rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
        chk("t5_rst_done", {inst_done, data_done}, 2'b00);
        chk("t5_rst_rdata", {inst_rdata, data_rdata}, 64'h0);
        inst_req = 0;
        set_delays(0, 0, 0, 0, 0);
        slave_reset();
        @(negedge clk) reset = 0;
        tick();
        inst_req = 1; inst_addr = 32'h1C00_0300;
        force_word = 32'h0F0F_0F0F; force_en = 1;
        wait_done(1'b1, 20, lat);
        chk("t5_lat", lat, 3);
        chk("t5_rdata", inst_rdata, 32'h0F0F_0F0F);
        chk("t5_araddr", last_araddr, 32'h1C00_0300);
        inst_req = 0;
        tick();

        // Randomized single requests; latency model from per-channel delays
        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 2);
            a = $urandom_range(0, 3); r = $urandom_range(0, 3);
            aw = $urandom_range(0, 3); w = $urandom_range(0, 3); b = $urandom_range(0, 3);
            set_delays(a, r, aw, w, b);
            addr = $urandom & 32'hFFFF_FFFC;
            wd = $urandom;
            ws = 4'($urandom_range(0, 15));
            if (kind == 0) begin
                inst_req = 1; inst_addr = addr;
                exp_lat = 3 + a + r;
            end else begin
                data_req = 1; data_wr = (kind == 2); data_addr = addr;
                data_wdata = wd; data_wstrb = ws;
                exp_lat = (kind == 2) ? 3 + ((aw > w) ? aw : w) + b : 3 + a + r;
            end
            wait_done(kind == 0, 40, lat);
            chk("rnd_lat", lat, exp_lat);
            if (kind == 0) begin
                chk("rnd_inst_rdata", inst_rdata, r_word);
                chk("rnd_inst_ar", {last_araddr, last_arid}, {addr, 4'd0});
            end else if (kind == 1) begin
                chk("rnd_data_rdata", data_rdata, r_word);
                chk("rnd_data_ar", {last_araddr, last_arid}, {addr, 4'd1});
            end else begin
                chk("rnd_aw", {last_awaddr, last_awid}, {addr, 4'd1});
                chk("rnd_w", {last_wdata, last_wstrb}, {wd, ws});
            end
            inst_req = 0; data_req = 0; data_wr = 0;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
